power_mode_sequencer: RTL and testbench

//  Sequences the PAD clock domain in and out of sleep: isolation, then clock gating, on

---
 rtl/power_mode_sequencer.sv | 189 ++++++++++++++++++
 tb/tb_power_mode_sequencer.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/power_mode_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : power_mode_sequencer
//  Description : Moves the PAD clock domain into and out of sleep.
//                Entry order: isolate the PAD outputs, then gate the clock.
//                Exit order : restore the clock, then release isolation.
//                Entry is caused by an inactivity timeout or a software
//                sleep request. Exit is caused by a wake request or by pad
//                activity.
//  Ports       : clk_in        system clock (always running)
//                rst_n_in      asynchronous active-low reset
//                activity_in   pad activity seen this cycle
//                sleep_req     software force-sleep (level)
//                wake_req      wake request (level)
//                clk_en_out    PAD clock-gate enable (1 = clock runs)
//                iso_en_out    PAD output isolation (1 = isolated)
//                pad_rst_n_out PAD-domain active-low reset
//                mode_out      00 ACTIVE, 01 ENTERING, 10 SLEEP, 11 WAKING
//                busy_out      1 in ISOLATE, WAKE_CLK and EXIT_ISO
//  Config      : PMS_SLEEP_RESET_EN - when defined, the PAD domain is held
//                in reset while asleep and released inside WAKE_CLK.
//  Revision    : 1.0 - initial release
// ============================================================================
module power_mode_sequencer #(
    parameter int IDLE_TIMEOUT = 16,  // >= 2
    parameter int SETTLE_CYC   = 4,   // >= 2
    parameter int CNT_W        = 8
) (
    input  logic       clk_in,
    input  logic       rst_n_in,
    input  logic       activity_in,
    input  logic       sleep_req,
    input  logic       wake_req,
    output logic       clk_en_out,
    output logic       iso_en_out,
    output logic       pad_rst_n_out,
    output logic [1:0] mode_out,
    output logic       busy_out
);

    typedef enum logic [2:0] {
        ST_ACTIVE   = 3'd0,
        ST_ISOLATE  = 3'd1,
        ST_SLEEP    = 3'd2,
        ST_WAKE_CLK = 3'd3,
        ST_EXIT_ISO = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] c_idle_last   = CNT_W'(IDLE_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] c_settle_last = CNT_W'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0] c_cnt_max     = '1;

    localparam logic [1:0] c_mode_active   = 2'b00;
    localparam logic [1:0] c_mode_entering = 2'b01;
    localparam logic [1:0] c_mode_sleep    = 2'b10;
    localparam logic [1:0] c_mode_waking   = 2'b11;

    state_t           r_state;
    state_t           w_state_next;
    logic [CNT_W-1:0] r_idle_cnt;
    logic [CNT_W-1:0] w_idle_next;
    logic [CNT_W-1:0] r_settle_cnt;
    logic [CNT_W-1:0] w_settle_next;

    logic             w_clk_en_next;
    logic             w_iso_en_next;
    logic             w_pad_rst_n_next;
    logic [1:0]       w_mode_next;
    logic             w_busy_next;

    // Next-state and counter logic
    always_comb begin
        w_state_next  = r_state;
        w_idle_next   = r_idle_cnt;
        w_settle_next = r_settle_cnt;
        case (r_state)
            ST_ACTIVE: begin
                // sleep_req has priority over activity in the same cycle
                if (sleep_req) begin
                    w_state_next  = ST_ISOLATE;
                    w_idle_next   = '0;
                    w_settle_next = '0;
                end else if (activity_in) begin
                    w_idle_next = '0;
                end else if (r_idle_cnt == c_idle_last) begin
                    w_state_next  = ST_ISOLATE;
                    w_idle_next   = '0;
                    w_settle_next = '0;
                end else if (r_idle_cnt != c_cnt_max) begin
                    w_idle_next = r_idle_cnt + 1'b1;
                end
            end
            ST_ISOLATE: begin
                // Abort goes straight to EXIT_ISO: the clock was never gated
                if (wake_req || activity_in) begin
                    w_state_next = ST_EXIT_ISO;
                end else if (r_settle_cnt == c_settle_last) begin
                    w_state_next = ST_SLEEP;
                end else begin
                    w_settle_next = r_settle_cnt + 1'b1;
                end
            end
            ST_SLEEP: begin
                if (wake_req || activity_in) begin
                    w_state_next  = ST_WAKE_CLK;
                    w_settle_next = '0;
                end
            end
            ST_WAKE_CLK: begin
                if (r_settle_cnt == c_settle_last) begin
                    w_state_next = ST_EXIT_ISO;
                end else begin
                    w_settle_next = r_settle_cnt + 1'b1;
                end
            end
            ST_EXIT_ISO: begin
                w_state_next = ST_ACTIVE;
                w_idle_next  = '0;
            end
            default: begin
                w_state_next  = ST_ACTIVE;
                w_idle_next   = '0;
                w_settle_next = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state so they change on the same
    // edge as the state register.
    always_comb begin
        w_clk_en_next = (w_state_next != ST_SLEEP);
        w_iso_en_next = (w_state_next == ST_ISOLATE) ||
                        (w_state_next == ST_SLEEP)   ||
                        (w_state_next == ST_WAKE_CLK);
        w_busy_next   = (w_state_next == ST_ISOLATE)  ||
                        (w_state_next == ST_WAKE_CLK) ||
                        (w_state_next == ST_EXIT_ISO);
        case (w_state_next)
            ST_ISOLATE:  w_mode_next = c_mode_entering;
            ST_SLEEP:    w_mode_next = c_mode_sleep;
            ST_WAKE_CLK: w_mode_next = c_mode_waking;
            ST_EXIT_ISO: w_mode_next = c_mode_waking;
            default:     w_mode_next = c_mode_active;
        endcase
    end

`ifdef PMS_SLEEP_RESET_EN
    // Domain reset asserts with the clock gate and releases two cycles
    // after the clock returns, while isolation is still on.
    always_comb begin
        w_pad_rst_n_next = 1'b1;
        if (w_state_next == ST_SLEEP) begin
            w_pad_rst_n_next = 1'b0;
        end else if ((w_state_next == ST_WAKE_CLK) &&
                     ((r_state == ST_SLEEP) || (r_settle_cnt == '0))) begin
            w_pad_rst_n_next = 1'b0;
        end
    end
`else
    // Domain reset only follows the block reset; state survives sleep.
    always_comb begin
        w_pad_rst_n_next = 1'b1;
    end
`endif

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_state       <= ST_ACTIVE;
            r_idle_cnt    <= '0;
            r_settle_cnt  <= '0;
            clk_en_out    <= 1'b1;
            iso_en_out    <= 1'b0;
            pad_rst_n_out <= 1'b0;
            mode_out      <= c_mode_active;
            busy_out      <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_idle_cnt    <= w_idle_next;
            r_settle_cnt  <= w_settle_next;
            clk_en_out    <= w_clk_en_next;
            iso_en_out    <= w_iso_en_next;
            pad_rst_n_out <= w_pad_rst_n_next;
            mode_out      <= w_mode_next;
            busy_out      <= w_busy_next;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_power_mode_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_power_mode_sequencer
//  Description : Self-checking bench for power_mode_sequencer
//                (IDLE_TIMEOUT=16, SETTLE_CYC=4). Expected outputs are
//                packed {clk_en, iso_en, pad_rst_n, mode[1:0], busy}.
//  Config      : honours PMS_SLEEP_RESET_EN for pad_rst_n expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_power_mode_sequencer;

    logic       clk_in = 1'b0;
    logic       rst_n_in = 1'b0;
    logic       activity_in = 1'b0;
    logic       sleep_req = 1'b0;
    logic       wake_req = 1'b0;
    logic       clk_en_out;
    logic       iso_en_out;
    logic       pad_rst_n_out;
    logic [1:0] mode_out;
    logic       busy_out;

    power_mode_sequencer #(
        .IDLE_TIMEOUT(16),
        .SETTLE_CYC  (4),
        .CNT_W       (8)
    ) u_dut (
        .clk_in       (clk_in),
        .rst_n_in     (rst_n_in),
        .activity_in  (activity_in),
        .sleep_req    (sleep_req),
        .wake_req     (wake_req),
        .clk_en_out   (clk_en_out),
        .iso_en_out   (iso_en_out),
        .pad_rst_n_out(pad_rst_n_out),
        .mode_out     (mode_out),
        .busy_out     (busy_out)
    );

    always #5 clk_in = ~clk_in;

`ifdef PMS_SLEEP_RESET_EN
    localparam logic c_sp = 1'b0;
`else
    localparam logic c_sp = 1'b1;
`endif

    localparam logic [5:0] E_RST = 6'b100000;
    localparam logic [5:0] E_ACT = 6'b101000;
    localparam logic [5:0] E_ISO = 6'b111011;
    localparam logic [5:0] E_SLP = {1'b0, 1'b1, c_sp, 2'b10, 1'b0};
    localparam logic [5:0] E_WK0 = {1'b1, 1'b1, c_sp, 2'b11, 1'b1};
    localparam logic [5:0] E_WK1 = 6'b111111;
    localparam logic [5:0] E_EXI = 6'b101111;

    typedef struct {
        logic       act;
        logic       slp;
        logic       wk;
        logic [5:0] exp;
    } vec_t;

    vec_t       tbl[33];
    logic [5:0] sb_q[$];
    int         n_vec = 0;
    int         n_err = 0;

    function automatic logic [5:0] observed();
        return {clk_en_out, iso_en_out, pad_rst_n_out, mode_out, busy_out};
    endfunction

    // Pop the oldest expectation and compare it with the outputs now.
    task automatic check(input string name);
        logic [5:0] e;
        logic [5:0] o;
        e = sb_q.pop_front();
        o = observed();
        n_vec++;
        if (o !== e) begin
            n_err++;
            $display("FAIL %s: got %b want %b (clk_en,iso,pad_rst_n,mode,busy)",
                     name, o, e);
        end
        if (!clk_en_out && !iso_en_out) begin
            n_err++;
            $display("FAIL %s ordering: clock gated while not isolated", name);
        end
    endtask

    // Drive one cycle of inputs from a negedge, check after the posedge.
    task automatic cyc(input logic a, input logic s, input logic w,
                       input logic [5:0] e, input string name);
        activity_in = a;
        sleep_req   = s;
        wake_req    = w;
        sb_q.push_back(e);
        @(posedge clk_in);
        #1;
        check(name);
        @(negedge clk_in);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // {act, slp, wk, expected} starting from SLEEP
        tbl[0]  = '{1'b0, 1'b1, 1'b0, E_SLP};  // sleep_req ignored asleep
        tbl[1]  = '{1'b0, 1'b0, 1'b1, E_WK0};  // wake pulse
        tbl[2]  = '{1'b0, 1'b0, 1'b0, E_WK0};
        tbl[3]  = '{1'b0, 1'b0, 1'b0, E_WK1};
        tbl[4]  = '{1'b0, 1'b0, 1'b0, E_WK1};
        tbl[5]  = '{1'b0, 1'b0, 1'b0, E_EXI};
        tbl[6]  = '{1'b0, 1'b0, 1'b0, E_ACT};
        tbl[7]  = '{1'b0, 1'b1, 1'b0, E_ISO};  // sleep_req at N
        tbl[8]  = '{1'b0, 1'b0, 1'b0, E_ISO};
        tbl[9]  = '{1'b1, 1'b0, 1'b0, E_EXI};  // activity at N+2 aborts
        tbl[10] = '{1'b0, 1'b0, 1'b0, E_ACT};
        tbl[11] = '{1'b1, 1'b1, 1'b0, E_ISO};  // sleep beats activity
        tbl[12] = '{1'b0, 1'b0, 1'b0, E_ISO};
        tbl[13] = '{1'b0, 1'b0, 1'b0, E_ISO};
        tbl[14] = '{1'b0, 1'b0, 1'b0, E_ISO};
        tbl[15] = '{1'b0, 1'b0, 1'b0, E_SLP};
        tbl[16] = '{1'b1, 1'b1, 1'b0, E_WK0};  // activity wakes, sleep held
        tbl[17] = '{1'b0, 1'b1, 1'b0, E_WK0};
        tbl[18] = '{1'b0, 1'b1, 1'b0, E_WK1};
        tbl[19] = '{1'b0, 1'b1, 1'b0, E_WK1};
        tbl[20] = '{1'b0, 1'b1, 1'b0, E_EXI};
        tbl[21] = '{1'b0, 1'b1, 1'b0, E_ACT};
        tbl[22] = '{1'b0, 1'b1, 1'b0, E_ISO};  // entry restarts
        tbl[23] = '{1'b0, 1'b0, 1'b1, E_EXI};  // wake aborts isolation
        tbl[24] = '{1'b0, 1'b0, 1'b0, E_ACT};
        tbl[25] = '{1'b0, 1'b0, 1'b1, E_ACT};  // wake ignored in ACTIVE
        tbl[26] = '{1'b0, 1'b1, 1'b0, E_ISO};
        tbl[27] = '{1'b0, 1'b0, 1'b0, E_ISO};
        tbl[28] = '{1'b0, 1'b0, 1'b0, E_ISO};
        tbl[29] = '{1'b0, 1'b0, 1'b0, E_ISO};
        tbl[30] = '{1'b0, 1'b0, 1'b0, E_SLP};
        tbl[31] = '{1'b0, 1'b0, 1'b1, E_WK0};
        tbl[32] = '{1'b0, 1'b0, 1'b0, E_WK0};

        // Reset state
        @(negedge clk_in);
        @(negedge clk_in);
        sb_q.push_back(E_RST);
        check("reset_state");
        rst_n_in = 1'b1;

        // Periodic activity keeps the domain awake; wake_req is ignored
        for (int i = 0; i < 100; i++) begin
            cyc((i % 8) == 0, 1'b0, (i % 5) == 0, E_ACT, "periodic_activity");
        end
        cyc(1'b1, 1'b0, 1'b0, E_ACT, "idle_clear");

        // Inactivity timeout, then settle into SLEEP
        for (int i = 0; i < 24; i++) begin
            cyc(1'b0, 1'b0, 1'b0,
                (i < 15) ? E_ACT : (i < 19) ? E_ISO : E_SLP, "idle_timeout");
        end

        for (int i = 0; i < 33; i++) begin
            cyc(tbl[i].act, tbl[i].slp, tbl[i].wk, tbl[i].exp, "table");
        end

        // Asynchronous reset while in WAKE_CLK
        #2;
        rst_n_in = 1'b0;
        #1;
        sb_q.push_back(E_RST);
        check("async_reset_in_wake");
        @(negedge clk_in);
        sb_q.push_back(E_RST);
        check("reset_held");
        rst_n_in = 1'b1;

        // One cycle short of the timeout must not trip it
        for (int i = 0; i < 15; i++) begin
            cyc(1'b0, 1'b0, 1'b0, E_ACT, "timeout_minus_one");
        end
        cyc(1'b1, 1'b0, 1'b0, E_ACT, "activity_at_boundary");
        for (int i = 0; i < 16; i++) begin
            cyc(1'b0, 1'b0, 1'b0, (i < 15) ? E_ACT : E_ISO, "timeout_after_clear");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
